fetch_unit: RTL and testbench

Instruction fetch front end for the SoC_risc core. Generates program-ROM read addresses, absorbs the ROM's one-cycle registered read latency, and buffers fetched 8-bit instructions in a 2-entry FIFO toward the execute stage over a valid/ready handshake. Supports control-flow redirects from execute (JMP/SKZ), detects HLT in the fetch stream, and sits between `prom` and the decode/execute stage.

---
 rtl/risc_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared widths, opcodes and field helpers for the SoC_risc core
package risc_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 8;
    localparam int OPC_W      = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Opcode lives in the top three bits of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [DW_DEFAULT-1:0] word);
        return word[DW_DEFAULT-1 -: OPC_W];
    endfunction

    // Operand is everything below the opcode (an address for LDA/STO/JMP).
    function automatic logic [DW_DEFAULT-OPC_W-1:0] operand_of(input logic [DW_DEFAULT-1:0] word);
        return word[DW_DEFAULT-OPC_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush and register-held head
module fetch_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage, pointers and occupancy; flush only rewinds pointers, stale data is masked by count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, ROM latency tracking, halt and redirect
module fetch_unit
    import risc_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_DOUT,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    input  logic          resume,
    output logic          halted
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    inflight_addr_q;
    logic             inflight_q;
    fetch_state_e     state_q;

    logic [CW-1:0]    count;
    logic [DW+AW-1:0] head;
    logic             pop;
    logic             push;
    logic             halt_capture;
    logic             issue;
    logic [CW:0]      occupancy;

    // A read is only issued if its word is guaranteed a FIFO slot when it returns.
    assign pop          = inst_valid && inst_ready;
    assign push         = inflight_q && !redirect;
    assign halt_capture = push && (MEM_DOUT[DW-1 -: OPC_W] == OP_HLT);
    assign occupancy    = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue        = (state_q == ST_RUN) && !halt_capture && !redirect
                          && (occupancy < (CW+1)'(DEPTH));

    // PC, in-flight read tracking and run/halt state; redirect overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            state_q         <= ST_RUN;
        end else if (redirect) begin
            pc_q       <= redirect_addr;
            inflight_q <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= pc_q;
                pc_q            <= pc_q + AW'(1);
            end
            if (halt_capture) begin
                state_q <= ST_HALT;
                pc_q    <= inflight_addr_q + AW'(1);
            end else if (state_q == ST_HALT && resume) begin
                state_q <= ST_RUN;
            end
        end
    end

    fetch_fifo #(
        .WIDTH(DW + AW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush_i    (redirect),
        .push_i     (push),
        .push_data_i({MEM_DOUT, inflight_addr_q}),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    assign MEM_ADDR   = pc_q;
    assign inst_valid = (count != '0);
    assign inst       = head[DW+AW-1:AW];
    assign inst_pc    = head[AW-1:0];
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a one-cycle registered ROM model
module tb_fetch_unit;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          resume = 1'b0;
    logic          halted;

    logic [DW-1:0]    rom [32];
    logic [DW+AW-1:0] exp_q [$];
    logic [DW+AW-1:0] sb_e;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= rom[mem_addr];

    fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_ADDR     (mem_addr),
        .MEM_DOUT     (mem_dout),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .resume       (resume),
        .halted       (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int a);
        exp_q.push_back({rom[a], AW'(a)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        reset      = 1'b0;
        redirect   = 1'b0;
        resume     = 1'b0;
        inst_ready = rdy;
        smp();
        check("rst_addr",   32'(mem_addr),   32'd0);
        check("rst_valid",  32'(inst_valid), 32'd0);
        check("rst_inst",   32'(inst),       32'd0);
        check("rst_pc",     32'(inst_pc),    32'd0);
        check("rst_halted", 32'(halted),     32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Scoreboard monitor: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h/%0d required=none", inst, inst_pc);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_inst", 32'(inst),    32'(sb_e[DW+AW-1:AW]));
                check("sb_pc",   32'(inst_pc), 32'(sb_e[AW-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h40 | 8'(i);
        rom[0]  = 8'hBF;
        rom[1]  = 8'h5E;
        rom[2]  = 8'hDA;
        rom[3]  = 8'hBF;
        rom[12] = 8'hE0;
        rom[13] = 8'h00;

        // Streaming from reset with execute always ready.
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) push_exp(k);
        smp();
        check("a_addr0",  32'(mem_addr),   32'd0);
        check("a_valid0", 32'(inst_valid), 32'd0);
        cyc(); smp();
        check("a_addr1",  32'(mem_addr),   32'd1);
        check("a_valid1", 32'(inst_valid), 32'd0);
        for (int k = 2; k < 6; k++) begin
            cyc(); smp();
            check("a_addr",  32'(mem_addr),   32'(k));
            check("a_valid", 32'(inst_valid), 32'd1);
        end
        cyc(); inst_ready = 1'b0; smp();
        check("a_sb_empty", 32'(exp_q.size()), 32'd0);
        cyc(); smp();
        check("a_full_valid", 32'(inst_valid), 32'd1);
        check("a_full_inst",  32'(inst),       32'h44);
        check("a_full_pc",    32'(inst_pc),    32'd4);
        check("a_full_addr",  32'(mem_addr),   32'd6);

        // Asynchronous reset in the middle of a cycle with the FIFO full.
        #2 reset = 1'b0;
        #1;
        check("async_addr",   32'(mem_addr),   32'd0);
        check("async_valid",  32'(inst_valid), 32'd0);
        check("async_inst",   32'(inst),       32'd0);
        check("async_pc",     32'(inst_pc),    32'd0);
        check("async_halted", 32'(halted),     32'd0);

        // Backpressure: head held, PC stalls, then back-to-back drain.
        do_reset(1'b0);
        smp();
        check("b_restart_addr", 32'(mem_addr), 32'd0);
        cyc(); smp();
        for (int k = 2; k < 8; k++) begin
            cyc(); smp();
            check("b_hold_valid", 32'(inst_valid), 32'd1);
            check("b_hold_inst",  32'(inst),       32'hBF);
            check("b_hold_pc",    32'(inst_pc),    32'd0);
            check("b_hold_addr",  32'(mem_addr),   32'd2);
        end
        for (int k = 0; k < 3; k++) push_exp(k);
        for (int k = 8; k < 11; k++) begin
            cyc();
            if (k == 8) inst_ready = 1'b1;
            smp();
            check("b_drain_valid", 32'(inst_valid), 32'd1);
        end
        cyc(); inst_ready = 1'b0; smp();
        check("b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Redirect with a full FIFO and a same-cycle pop, then HLT and resume.
        do_reset(1'b0);
        smp();
        cyc(); smp();
        cyc(); smp();
        cyc();
        inst_ready    = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 5'd12;
        push_exp(0);
        push_exp(12);
        push_exp(13);
        smp();
        cyc(); redirect = 1'b0; smp();
        check("c_flush_valid", 32'(inst_valid), 32'd0);
        check("c_redir_addr",  32'(mem_addr),   32'd12);
        cyc(); smp();
        check("c_gap_valid",   32'(inst_valid), 32'd0);
        check("c_addr13",      32'(mem_addr),   32'd13);
        cyc(); smp();
        check("c_e0_valid",    32'(inst_valid), 32'd1);
        check("c_pre_halt",    32'(halted),     32'd0);
        cyc(); smp();
        check("d_hlt_valid",   32'(inst_valid), 32'd1);
        check("d_halted",      32'(halted),     32'd1);
        check("d_halt_addr",   32'(mem_addr),   32'd14);
        for (int k = 0; k < 4; k++) begin
            cyc(); smp();
            check("d_idle_valid",  32'(inst_valid), 32'd0);
            check("d_idle_halted", 32'(halted),     32'd1);
            check("d_idle_addr",   32'(mem_addr),   32'd14);
        end
        cyc(); resume = 1'b1; push_exp(14); push_exp(15); smp();
        check("d_resume_cyc_halted", 32'(halted), 32'd1);
        cyc(); resume = 1'b0; smp();
        check("d_resumed",      32'(halted),   32'd0);
        check("d_restart_addr", 32'(mem_addr), 32'd14);
        cyc(); smp();
        check("d_addr15",       32'(mem_addr), 32'd15);
        cyc(); smp();
        check("d_v14", 32'(inst_valid), 32'd1);
        cyc(); smp();
        check("d_v15", 32'(inst_valid), 32'd1);
        cyc(); inst_ready = 1'b0; smp();
        check("d_sb_empty", 32'(exp_q.size()), 32'd0);

        // Redirect over a capture, to the top address, then wrap to 0.
        do_reset(1'b1);
        smp();
        cyc(); redirect = 1'b1; redirect_addr = 5'd31; smp();
        cyc(); redirect = 1'b0;
        push_exp(31);
        for (int k = 0; k < 3; k++) push_exp(k);
        smp();
        check("e_drop_valid", 32'(inst_valid), 32'd0);
        check("e_addr31",     32'(mem_addr),   32'd31);
        cyc(); smp();
        check("e_gap_valid",  32'(inst_valid), 32'd0);
        check("e_wrap_addr",  32'(mem_addr),   32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); smp();
            check("e_valid", 32'(inst_valid), 32'd1);
        end
        cyc(); inst_ready = 1'b0; smp();
        check("e_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
